// File: rtl/cic_pkg.sv
// Shared definitions for the multi-channel CIC decimator: default sizes,
// controller state encoding and the stage-count clamp.
package cic_pkg;

   localparam int MAX_STAGES_DEF = 5;
   localparam int OUT_W_DEF      = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COMB = 2'd1,
      S_OUT  = 2'd2
   } cic_state_e;

   // 0 selects a single stage; anything above the built stage count saturates.
   function automatic logic [2:0] clamp_stages(input logic [2:0] comb_num,
                                               input int         max_stages);
      if (comb_num == 3'd0)
         return 3'd1;
      if (int'(comb_num) > max_stages)
         return 3'(max_stages);
      return comb_num;
   endfunction

endpackage

// File: rtl/cic_integ_chain.sv
// One channel's integrator cascade. Maps the PDM bit to +1/-1 and updates all
// stages on din_en; sum_nxt exposes the post-update values for snapshotting.
module cic_integ_chain #(
   parameter int STAGES = 5,
   parameter int W      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din,
   input  logic                     din_en,
   output logic [STAGES-1:0][W-1:0] sum_nxt
);

   logic [STAGES-1:0][W-1:0] sum_q;
   logic [W-1:0]             acc;

   // Each stage accumulates the freshly updated value of the stage below it.
   always_comb begin
      sum_nxt = sum_q;
      acc     = '0;
      if (din_en) begin
         acc        = sum_q[0] + (din ? W'(1) : {W{1'b1}});
         sum_nxt[0] = acc;
         for (int k = 1; k < STAGES; k++) begin
            acc        = sum_q[k] + acc;
            sum_nxt[k] = acc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sum_q <= '0;
      else
         sum_q <= sum_nxt;
   end

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel PDM CIC decimator: free-running per-channel integrators, one
// time-multiplexed comb shared by all channels, and a valid/ready sample stream.
module cic_decim_mc
   import cic_pkg::*;
#(
   parameter int  CHANNELS   = 4,
   parameter int  MAX_STAGES = MAX_STAGES_DEF,
   parameter int  RATE_W     = 16,
   parameter int  OUT_W      = OUT_W_DEF,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   input  logic                din_en,
   input  logic [RATE_W-1:0]   dec_num,
   input  logic [2:0]          comb_num,
   output logic [OUT_W-1:0]    out,
   output logic [CH_W-1:0]     out_ch,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun,
   output cic_state_e          state_dbg
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   logic [CHANNELS-1:0][MAX_STAGES-1:0][OUT_W-1:0] sum_nxt;
   logic [RATE_W-1:0] dec_cnt, r_cur, eff_r;
   logic [2:0]        n_cur, eff_n, frame_n;
   logic              boundary, accept;
   logic [OUT_W-1:0]  snap     [CHANNELS];
   logic [OUT_W-1:0]  dly      [CHANNELS][MAX_STAGES];
   logic [OUT_W-1:0]  res      [CHANNELS];
   logic [OUT_W-1:0]  comb_tap [MAX_STAGES];
   logic [OUT_W-1:0]  comb_val;
   logic [CH_W-1:0]   ch_idx;
   cic_state_e        state, state_nxt;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      cic_integ_chain #(
         .STAGES (MAX_STAGES),
         .W      (OUT_W)
      ) u_integ (
         .clk     (clk),
         .rst     (rst),
         .din     (din[c]),
         .din_en  (din_en),
         .sum_nxt (sum_nxt[c])
      );
   end

   // R and N come live from the inputs only on the first din_en of a period.
   always_comb begin
      eff_r = r_cur;
      eff_n = n_cur;
      if (dec_cnt == '0) begin
         eff_r = (dec_num == '0) ? RATE_W'(1) : dec_num;
         eff_n = clamp_stages(comb_num, MAX_STAGES);
      end
   end

   assign boundary = din_en && (dec_cnt == eff_r - RATE_W'(1));
   assign accept   = boundary && (state == S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_cnt <= '0;
         r_cur   <= RATE_W'(1);
         n_cur   <= 3'd1;
         frame_n <= 3'd1;
         overrun <= 1'b0;
      end else begin
         if (din_en) begin
            dec_cnt <= boundary ? '0 : dec_cnt + RATE_W'(1);
            if (dec_cnt == '0) begin
               r_cur <= eff_r;
               n_cur <= eff_n;
            end
         end
         if (boundary && (state != S_IDLE))
            overrun <= 1'b1;
         if (accept)
            frame_n <= eff_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CHANNELS; c++)
            snap[c] <= '0;
      end else if (accept) begin
         for (int c = 0; c < CHANNELS; c++)
            snap[c] <= sum_nxt[c][eff_n - 3'd1];
      end
   end

   // Shared comb: stages at or above the frame's N pass the value through.
   always_comb begin
      comb_val = snap[ch_idx];
      for (int k = 0; k < MAX_STAGES; k++) begin
         comb_tap[k] = comb_val;
         if (k < int'(frame_n))
            comb_val = comb_val - dly[ch_idx][k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            res[c] <= '0;
            for (int k = 0; k < MAX_STAGES; k++)
               dly[c][k] <= '0;
         end
      end else if (state == S_COMB) begin
         res[ch_idx] <= comb_val;
         for (int k = 0; k < MAX_STAGES; k++)
            if (k < int'(frame_n))
               dly[ch_idx][k] <= comb_tap[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ch_idx <= '0;
      else if ((state == S_COMB) || ((state == S_OUT) && out_ready))
         ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + CH_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_COMB;
         S_COMB:  if (ch_idx == LAST_CH) state_nxt = S_OUT;
         S_OUT:   if (out_ready && (ch_idx == LAST_CH)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A sample transfers on any cycle with out_valid && out_ready; while
   // out_valid is high and out_ready low, out/out_ch/out_valid do not change.
   always_comb begin
      out_valid = (state == S_OUT);
      out_ch    = out_valid ? ch_idx : '0;
      out       = out_valid ? res[ch_idx] : '0;
      state_dbg = state;
   end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Self-checking bench for cic_decim_mc: a cycle-level behavioural model
// predicts every output, and literal pins confirm the known settled gains.
module tb_cic_decim_mc;
   import cic_pkg::*;

   localparam int CH = 4;
   localparam int MS = 5;
   localparam int RW = 16;
   localparam int W  = 32;

   logic          clk;
   logic          rst;
   logic [CH-1:0] din;
   logic          din_en;
   logic [RW-1:0] dec_num;
   logic [2:0]    comb_num;
   logic [W-1:0]  out;
   logic [1:0]    out_ch;
   logic          out_valid;
   logic          out_ready;
   logic          overrun;
   cic_state_e    state_dbg;

   cic_decim_mc #(
      .CHANNELS   (CH),
      .MAX_STAGES (MS),
      .RATE_W     (RW),
      .OUT_W      (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_en    (din_en),
      .dec_num   (dec_num),
      .comb_num  (comb_num),
      .out       (out),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] exp_q[$];
   int           exp_ch_q[$];
   logic [W-1:0] m_integ [CH][MS];
   logic [W-1:0] m_dly   [CH][MS];
   int           m_cnt, m_r, m_n, m_valid_from;
   bit           m_busy, m_overrun;
   bit           pin_on = 0, pin_ovr = 0, lat_pin = 0, end_req = 0, end_done = 0;
   logic [W-1:0] pin_val = '0;
   int           en_cnt, fourth_cyc;
   bit           lat_done;
   int           tmo_events = 0, tmo_seen = 0;
   bit           found;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < MS; k++) begin
            m_integ[c][k] = '0;
            m_dly[c][k]   = '0;
         end
      m_cnt = 0; m_r = 1; m_n = 1; m_valid_from = 0;
      m_busy = 0; m_overrun = 0;
      exp_q.delete(); exp_ch_q.delete();
      en_cnt = 0; fourth_cyc = 0; lat_done = 0;
   endtask

   // ---------------- compare process + model step ----------------
   always @(negedge clk) begin
      logic         exp_valid, xfer, fin, bnd;
      logic [W-1:0] v, t;
      cyc++;
      if (tmo_events != tmo_seen) begin
         checks++; errors++;
         $display("FAIL timeout: expired waits %0d expected 0", tmo_events);
         tmo_seen = tmo_events;
      end
      if (!rst) begin
         chk("rst_out", out, '0);
         chk("rst_out_ch", W'(out_ch), '0);
         chk("rst_out_valid", W'(out_valid), '0);
         chk("rst_overrun", W'(overrun), '0);
         model_reset();
      end else begin
         exp_valid = m_busy && (cyc >= m_valid_from);
         chk("out_valid", W'(out_valid), W'(exp_valid));
         if (exp_valid && out_valid && exp_q.size() > 0) begin
            chk("out", out, exp_q[0]);
            chk("out_ch", W'(out_ch), W'(exp_ch_q[0]));
            if (pin_on) chk("pin_out", out, pin_val);
         end
         chk("overrun", W'(overrun), W'(m_overrun));
         if (pin_ovr) chk("pin_overrun", W'(overrun), W'(1));
         if (lat_pin) begin
            if (din_en) begin
               en_cnt++;
               if (en_cnt == 4) fourth_cyc = cyc;
            end
            if (out_valid && !lat_done && en_cnt >= 4) begin
               chk("latency", W'(cyc - fourth_cyc), W'(5));
               lat_done = 1;
            end
         end
         if (end_req && !end_done) begin
            chk("drained", W'(exp_q.size()), '0);
            chk("idle_end", W'(m_busy), '0);
            end_done = 1;
         end

         // what the next rising edge does
         xfer = exp_valid && out_ready && (exp_q.size() > 0);
         fin  = 0;
         bnd  = 0;
         if (xfer) begin
            fin = (exp_ch_q[0] == CH - 1);
            void'(exp_q.pop_front());
            void'(exp_ch_q.pop_front());
         end
         if (din_en) begin
            if (m_cnt == 0) begin
               m_r = (dec_num == 0) ? 1 : int'(dec_num);
               m_n = (comb_num == 0) ? 1 : (int'(comb_num) > MS) ? MS : int'(comb_num);
            end
            for (int c = 0; c < CH; c++) begin
               m_integ[c][0] = m_integ[c][0] + (din[c] ? W'(1) : {W{1'b1}});
               for (int k = 1; k < MS; k++)
                  m_integ[c][k] = m_integ[c][k] + m_integ[c][k-1];
            end
            m_cnt++;
            if (m_cnt == m_r) begin
               m_cnt = 0;
               bnd = 1;
            end
         end
         if (bnd) begin
            if (m_busy) begin
               m_overrun = 1;
            end else begin
               for (int c = 0; c < CH; c++) begin
                  v = m_integ[c][m_n-1];
                  for (int k = 0; k < m_n; k++) begin
                     t = v - m_dly[c][k];
                     m_dly[c][k] = v;
                     v = t;
                  end
                  exp_q.push_back(v);
                  exp_ch_q.push_back(c);
               end
               m_busy = 1;
               m_valid_from = cyc + 1 + CH;
            end
         end
         if (fin) m_busy = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic pulse(input logic [CH-1:0] v, input int gap);
      din = v;
      din_en = 1'b1;
      @(posedge clk); #1;
      din_en = 1'b0;
      repeat (gap - 1) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_settle(input int mode, input int r, input int n, input int gap,
                             input int n_en, input int pin_after, input logic [W-1:0] pv);
      logic [CH-1:0] d;
      dec_num = RW'(r);
      comb_num = 3'(n);
      out_ready = 1'b1;
      pin_val = pv;
      do_reset();
      for (int i = 1; i <= n_en; i++) begin
         case (mode)
            0:       d = '1;
            1:       d = '0;
            default: d = (i % 2 == 1) ? '1 : '0;
         endcase
         pulse(d, gap);
         if (i == pin_after) pin_on = 1;
      end
      repeat (20) @(posedge clk);
      #1 pin_on = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; din = '0; din_en = 1'b0; dec_num = 16'd4; comb_num = 3'd4; out_ready = 1'b1;

      run_settle(0, 4, 4, 3, 40, 24, 32'd256);
      run_settle(1, 4, 4, 3, 40, 24, 32'hFFFF_FF00);
      run_settle(2, 4, 4, 3, 40, 24, 32'd0);
      run_settle(0, 8, 1, 2, 40, 16, 32'd8);
      run_settle(0, 8, 0, 2, 40, 16, 32'd8);
      run_settle(0, 8, 7, 2, 64, 48, 32'd32768);

      // downstream stalls across whole periods
      dec_num = 16'd4; comb_num = 3'd4;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) pulse('1, 3);
      pin_ovr = 1;
      repeat (4) @(posedge clk);
      #1 out_ready = 1'b1;
      for (int i = 0; i < 16; i++) pulse('1, 3);
      repeat (20) @(posedge clk);
      #1 pin_ovr = 0;

      // reset while presenting channel 2
      do_reset();
      found = 0;
      din_en = 1'b1;
      for (int i = 0; i < 100 && !found; i++) begin
         din = CH'($urandom_range(0, 15));
         @(posedge clk); #1;
         if (out_valid && out_ch == 2'd2) found = 1;
      end
      if (!found) tmo_events++;
      rst = 1'b0; din_en = 1'b0; lat_pin = 1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = CH'($urandom_range(0, 15));
         din_en = 1'b1;
         @(posedge clk); #1;
      end
      din_en = 1'b0;
      repeat (15) @(posedge clk);
      #1 lat_pin = 0;

      // rate change in the middle of a period
      dec_num = 16'd4;
      do_reset();
      pulse('1, 3);
      pulse('1, 3);
      dec_num = 16'd8;
      for (int i = 0; i < 22; i++) pulse(CH'($urandom_range(0, 15)), 3);
      repeat (20) @(posedge clk); #1;

      // randomized traffic, rates, stage counts and back-pressure
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            dec_num  = RW'($urandom_range(0, 6));
            comb_num = 3'($urandom_range(0, 7));
         end
         din       = CH'($urandom_range(0, 15));
         din_en    = ($urandom_range(0, 2) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      din_en = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(posedge clk); #1;

      end_req = 1;
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
